biquad_bandpass: RTL

- Second-order IIR (Direct Form I biquad) band-pass stage directly upstream of the band-power accumulator.
- Filters raw ECG samples; each filtered sample is presented with a one-cycle strobe that drives the power stage's valid/x_in pair.
- One time-multiplexed multiplier performs five MACs per sample under a small FSM.

---
 rtl/ecg_dsp_pkg.sv | 44 ++++
 rtl/biquad_mac.sv | 29 ++
 rtl/biquad_bandpass.sv | 139 +++++++++++++
 3 files changed

// File: rtl/ecg_dsp_pkg.sv
// Shared Q-format constants, FSM state type, coefficient map and output rounding for the ECG DSP chain.
package ecg_dsp_pkg;

    localparam int DATA_W    = 16;
    localparam int COEF_W    = 16;
    localparam int COEF_FRAC = 14;
    localparam int ACC_W     = 40;
    localparam int NUM_TAPS  = 5;

    localparam logic [2:0] CA_B0 = 3'd0;
    localparam logic [2:0] CA_B1 = 3'd1;
    localparam logic [2:0] CA_B2 = 3'd2;
    localparam logic [2:0] CA_A1 = 3'd3;
    localparam logic [2:0] CA_A2 = 3'd4;

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    typedef struct packed {
        logic signed [DATA_W-1:0] y;
        logic                     clip;
    } sat_t;

    localparam logic signed [ACC_W-1:0]  RND     = ACC_W'(2 ** (COEF_FRAC - 1));
    localparam logic signed [ACC_W-1:0]  SAT_MAX = ACC_W'(2 ** (DATA_W - 1) - 1);
    localparam logic signed [ACC_W-1:0]  SAT_MIN = ACC_W'(-(2 ** (DATA_W - 1)));
    localparam logic signed [DATA_W-1:0] Y_MAX   = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] Y_MIN   = {1'b1, {(DATA_W-1){1'b0}}};

    // Round half up, drop the coefficient fraction, clip into the sample range.
    function automatic sat_t round_sat(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] r;
        sat_t o;
        r = (acc + RND) >>> COEF_FRAC;
        if (r > SAT_MAX) begin
            o.y = Y_MAX; o.clip = 1'b1;
        end else if (r < SAT_MIN) begin
            o.y = Y_MIN; o.clip = 1'b1;
        end else begin
            o.y = r[DATA_W-1:0]; o.clip = 1'b0;
        end
        return o;
    endfunction

endpackage

// File: rtl/biquad_mac.sv
// Single multiplier with a 40-bit accumulator; feedback taps are subtracted via neg.
module biquad_mac
    import ecg_dsp_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     en,
    input  logic                     neg,
    input  logic signed [COEF_W-1:0] coef,
    input  logic signed [DATA_W-1:0] data,
    output logic signed [ACC_W-1:0]  acc
);

    localparam int PROD_W = COEF_W + DATA_W;

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  term;

    assign prod = coef * data;
    assign term = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};

    always_ff @(posedge clk) begin
        if (!rst)       acc <= '0;
        else if (clear) acc <= '0;
        else if (en)    acc <= neg ? acc - term : acc + term;
    end

endmodule

// File: rtl/biquad_bandpass.sv
// Direct Form I biquad band-pass, one shared MAC, 7 clocks per sample.
// Define BIQUAD_COEF_WR_EN for a writable coefficient bank (shadowed per sample).
module biquad_bandpass
    import ecg_dsp_pkg::*;
#(
    parameter logic signed [COEF_W-1:0] B0 = COEF_W'(1530),
    parameter logic signed [COEF_W-1:0] B1 = COEF_W'(0),
    parameter logic signed [COEF_W-1:0] B2 = COEF_W'(-1530),
    parameter logic signed [COEF_W-1:0] A1 = COEF_W'(-27600),
    parameter logic signed [COEF_W-1:0] A2 = COEF_W'(13324)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] x_in,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] y_out,
    output logic                     sat_pulse
`ifdef BIQUAD_COEF_WR_EN
    ,
    input  logic                     coef_we,
    input  logic [2:0]               coef_addr,
    input  logic signed [COEF_W-1:0] coef_data
`endif
);

    localparam logic [NUM_TAPS-1:0][COEF_W-1:0] COEF_DEF = {A2, A1, B2, B1, B0};

    state_t                   state, state_nx;
    logic [2:0]               idx;
    logic                     accept, mac_clr, mac_en, m_neg;
    logic signed [DATA_W-1:0] xs, x1, x2, y1, y2, m_data;
    logic signed [COEF_W-1:0] m_coef;
    logic signed [ACC_W-1:0]  acc;
    logic [NUM_TAPS-1:0][COEF_W-1:0] coefs;
    sat_t                     res;

`ifdef BIQUAD_COEF_WR_EN
    logic [NUM_TAPS-1:0][COEF_W-1:0] live;

    // Writes land in the live bank; the MAC only sees the copy taken at accept.
    always_ff @(posedge clk) begin
        if (!rst) begin
            live  <= COEF_DEF;
            coefs <= COEF_DEF;
        end else begin
            if (coef_we && coef_addr <= CA_A2) live[coef_addr] <= coef_data;
            if (accept) coefs <= live;
        end
    end
`else
    assign coefs = COEF_DEF;
`endif

    assign accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = MAC;
            MAC:     if (idx == CA_A2) state_nx = OUT;
            OUT:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == IDLE);
        mac_en   = (state == MAC);
        mac_clr  = accept;
    end

    always_comb begin
        m_coef = '0;
        m_data = '0;
        m_neg  = 1'b0;
        case (idx)
            CA_B0: begin m_coef = coefs[0]; m_data = xs; end
            CA_B1: begin m_coef = coefs[1]; m_data = x1; end
            CA_B2: begin m_coef = coefs[2]; m_data = x2; end
            CA_A1: begin m_coef = coefs[3]; m_data = y1; m_neg = 1'b1; end
            CA_A2: begin m_coef = coefs[4]; m_data = y2; m_neg = 1'b1; end
            default: ;
        endcase
    end

    biquad_mac u_mac (
        .clk   (clk),
        .rst   (rst),
        .clear (mac_clr),
        .en    (mac_en),
        .neg   (m_neg),
        .coef  (m_coef),
        .data  (m_data),
        .acc   (acc)
    );

    assign res = round_sat(acc);

    // Feedback history takes the clipped value, same as what leaves the block.
    always_ff @(posedge clk) begin
        if (!rst) begin
            idx       <= '0;
            xs        <= '0;
            x1        <= '0;
            x2        <= '0;
            y1        <= '0;
            y2        <= '0;
            y_out     <= '0;
            out_valid <= 1'b0;
            sat_pulse <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            sat_pulse <= 1'b0;
            if (accept) begin
                idx <= '0;
                xs  <= x_in;
            end else if (state == MAC) begin
                idx <= idx + 3'd1;
            end
            if (state == OUT) begin
                y_out     <= res.y;
                out_valid <= 1'b1;
                sat_pulse <= res.clip;
                x2        <= x1;
                x1        <= xs;
                y2        <= y1;
                y1        <= res.y;
            end
        end
    end

endmodule
